// File: rtl/obj_mem_pkg.sv
// rtl/obj_mem_pkg.sv - shared types and defaults for the object memory
package obj_mem_pkg;

  localparam int WORD_SIZE     = 32;
  localparam int OBJ_MEM_DEPTH = 128;

  typedef enum logic {
    mem_ok  = 1'b0,
    mem_oob = 1'b1
  } mem_status_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } obj_mem_state_t;

endpackage

// File: rtl/obj_mem_array.sv
// rtl/obj_mem_array.sv - plain 1R1W synchronous storage with registered read
module obj_mem_array #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 128,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              re,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  // No reset on the array so it can map onto block RAM
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/obj_mem.sv
// rtl/obj_mem.sv - object store with clear sequencer, bounds status and 1-entry response buffer
module obj_mem
  import obj_mem_pkg::*;
#(
  parameter int                WORD_W   = WORD_SIZE,
  parameter int                DEPTH    = OBJ_MEM_DEPTH,
  parameter int                ADDR_W   = 8,
  parameter logic [WORD_W-1:0] NIL_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output mem_status_t       rsp_status,
  output logic              init_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_PTR  = AW'(DEPTH - 1);

  obj_mem_state_t    state;
  logic [AW-1:0]     clr_ptr;
  logic              rsp_is_read;
  logic              accept;
  logic              in_bounds;
  logic [AW-1:0]     user_addr;
  logic              arr_we;
  logic [AW-1:0]     arr_wr_addr;
  logic [WORD_W-1:0] arr_wr_data;
  logic              arr_re;
  logic [WORD_W-1:0] arr_rd_data;

  assign req_ready = (state == ST_RUN) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Full-width compare: no truncation or wrap of out-of-range addresses
  assign in_bounds = ({1'b0, req_addr} < DEPTH_CMP);
  assign user_addr = in_bounds ? req_addr[AW-1:0] : '0;

  assign arr_we      = (state == ST_CLEAR) || (accept && req_we && in_bounds);
  assign arr_wr_addr = (state == ST_CLEAR) ? clr_ptr : user_addr;
  assign arr_wr_data = (state == ST_CLEAR) ? NIL_WORD : req_data;
  assign arr_re      = accept && !req_we;

  // Read data only moves on an accepted read, so it holds across stalls
  assign rsp_data = rsp_is_read ? arr_rd_data : NIL_WORD;

  obj_mem_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk     (clk),
    .we      (arr_we),
    .wr_addr (arr_wr_addr),
    .wr_data (arr_wr_data),
    .re      (arr_re),
    .rd_addr (user_addr),
    .rd_data (arr_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_CLEAR;
      clr_ptr     <= '0;
      init_done   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_is_read <= 1'b0;
      rsp_status  <= mem_ok;
    end else begin
      if (state == ST_CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (clr_ptr == LAST_PTR) begin
          state     <= ST_RUN;
          init_done <= 1'b1;
        end
      end
      if (accept) begin
        rsp_valid   <= 1'b1;
        rsp_is_read <= !req_we;
        rsp_status  <= in_bounds ? mem_ok : mem_oob;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_obj_mem.sv
// tb/tb_obj_mem.sv - randomized and directed checks of obj_mem against a transaction model
module tb_obj_mem;
  import obj_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: DEPTH 128, ADDR_W 8
  logic        a_rst_n = 1'b0, a_req_valid = 1'b0, a_req_we = 1'b0, a_rsp_ready = 1'b0;
  logic [7:0]  a_req_addr = '0;
  logic [31:0] a_req_data = '0;
  logic        a_req_ready, a_rsp_valid, a_init_done;
  logic [31:0] a_rsp_data;
  mem_status_t a_rsp_status;

  // DUT B: DEPTH 100, ADDR_W 7
  logic        b_rst_n = 1'b0, b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b0;
  logic [6:0]  b_req_addr = '0;
  logic [31:0] b_req_data = '0;
  logic        b_req_ready, b_rsp_valid, b_init_done;
  logic [31:0] b_rsp_data;
  mem_status_t b_rsp_status;

  obj_mem #(.WORD_W(32), .DEPTH(128), .ADDR_W(8), .NIL_WORD(32'h0)) u_a (
    .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_data(a_req_data),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .rsp_status(a_rsp_status), .init_done(a_init_done));

  obj_mem #(.WORD_W(32), .DEPTH(100), .ADDR_W(7), .NIL_WORD(32'h0)) u_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_data(b_req_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_status(b_rsp_status), .init_done(b_init_done));

  typedef struct {
    logic [31:0] data;
    logic        oob;
  } rsp_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model_mem [128];
  rsp_t        rq[$];
  logic        model_init = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) model_mem[i] = 32'h0;
    rq.delete();
    model_init = 1'b0;
  endtask

  // Count clear cycles after a release on a negedge; ready tracks init_done with no response pending
  task automatic count_clear(input int n_cyc, input bit with_b);
    for (int k = 1; k <= n_cyc; k++) begin
      @(negedge clk);
      check("a_init_done", a_init_done, k >= 128);
      check("a_req_ready_clear", a_req_ready, k >= 128);
      if (with_b) begin
        check("b_init_done", b_init_done, k >= 100);
        check("b_req_ready_clear", b_req_ready, k >= 100);
      end
    end
    if (n_cyc >= 128) model_init = 1'b1;
  endtask

  // One cycle on DUT A: drive, compare against the model just before the edge, then advance
  task automatic step_a(input logic v, input logic we, input logic [7:0] addr,
                        input logic [31:0] d, input logic rr);
    logic exp_ready;
    rsp_t r;
    a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_data = d; a_rsp_ready = rr;
    #1;
    exp_ready = model_init && (rq.size() == 0 || rr);
    check("req_ready", a_req_ready, exp_ready);
    check("rsp_valid", a_rsp_valid, rq.size() != 0);
    if (rq.size() != 0) begin
      check("rsp_data", a_rsp_data, rq[0].data);
      check("rsp_status", a_rsp_status, rq[0].oob);
      if (rr) void'(rq.pop_front());
    end
    if (v && exp_ready) begin
      r.oob = (addr >= 8'd128);
      if (we) begin
        r.data = 32'h0;
        if (!r.oob) model_mem[addr[6:0]] = d;
      end else begin
        r.data = r.oob ? model_mem[0] : model_mem[addr[6:0]];
      end
      rq.push_back(r);
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_rsp_valid", a_rsp_valid, 1'b0);
    check("reset_rsp_data", a_rsp_data, 32'h0);
    check("reset_rsp_status", a_rsp_status, mem_ok);
    check("reset_init_done", a_init_done, 1'b0);
    check("reset_req_ready", a_req_ready, 1'b0);
    @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    count_clear(128, 1'b1);

    // Every word cleared, streamed one read per cycle
    for (int i = 0; i < 128; i++) step_a(1'b1, 1'b0, 8'(i), 32'h0, 1'b1);
    step_a(1'b0, 1'b0, 8'h0, 32'h0, 1'b1);

    // Write then back-to-back read of the same address
    step_a(1'b1, 1'b1, 8'd5, 32'hDEADBEEF, 1'b1);
    step_a(1'b1, 1'b0, 8'd5, 32'h0, 1'b1);
    step_a(1'b0, 1'b0, 8'd0, 32'h0, 1'b1);

    // Out-of-bounds read aliases word 0; out-of-bounds write leaves memory untouched
    step_a(1'b1, 1'b1, 8'd0, 32'h11, 1'b1);
    step_a(1'b1, 1'b0, 8'd200, 32'h0, 1'b1);
    step_a(1'b1, 1'b1, 8'd128, 32'h22, 1'b1);
    step_a(1'b1, 1'b0, 8'd0, 32'h0, 1'b1);
    step_a(1'b1, 1'b0, 8'd255, 32'h0, 1'b1);
    step_a(1'b0, 1'b0, 8'd0, 32'h0, 1'b1);

    // Backpressure: response must hold while requests wait
    step_a(1'b1, 1'b0, 8'd5, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step_a(1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    step_a(1'b1, 1'b0, 8'd0, 32'h0, 1'b1);
    step_a(1'b0, 1'b0, 8'd0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
             $urandom, $urandom_range(0, 3) != 0);
    step_a(1'b0, 1'b0, 8'd0, 32'h0, 1'b1);

    // Non-power-of-two depth bounds on DUT B
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 7'd99; b_req_data = 32'hABC; b_rsp_ready = 1'b1;
    #1;
    check("b_req_ready", b_req_ready, 1'b1);
    @(negedge clk);
    b_req_we = 1'b0; b_req_addr = 7'd99;
    #1;
    check("b_wr99_valid", b_rsp_valid, 1'b1);
    check("b_wr99_status", b_rsp_status, mem_ok);
    check("b_wr99_data", b_rsp_data, 32'h0);
    @(negedge clk);
    b_req_addr = 7'd100;
    #1;
    check("b_rd99_data", b_rsp_data, 32'hABC);
    check("b_rd99_status", b_rsp_status, mem_ok);
    @(negedge clk);
    b_req_addr = 7'd127;
    #1;
    check("b_rd100_data", b_rsp_data, 32'h0);
    check("b_rd100_status", b_rsp_status, mem_oob);
    @(negedge clk);
    b_req_valid = 1'b0;
    #1;
    check("b_rd127_status", b_rsp_status, mem_oob);
    @(negedge clk);
    #1;
    check("b_idle_valid", b_rsp_valid, 1'b0);
    @(negedge clk);

    // Reset with a response pending, then again mid-clear
    step_a(1'b1, 1'b1, 8'd5, 32'hDEADBEEF, 1'b1);
    step_a(1'b1, 1'b0, 8'd5, 32'h0, 1'b0);
    a_req_valid = 1'b0;
    #1;
    check("pre_reset_valid", a_rsp_valid, 1'b1);
    #2;
    a_rst_n = 1'b0;
    #1;
    check("async_reset_valid", a_rsp_valid, 1'b0);
    check("async_reset_data", a_rsp_data, 32'h0);
    check("async_reset_status", a_rsp_status, mem_ok);
    check("async_reset_ready", a_req_ready, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    a_rst_n = 1'b1;
    count_clear(60, 1'b0);
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    count_clear(128, 1'b0);
    step_a(1'b1, 1'b0, 8'd5, 32'h0, 1'b1);
    step_a(1'b0, 1'b0, 8'd0, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/obj_mem.md
Name: obj_mem

Overview:
- Parametrised successor of the single-port object RAM.
- Word-addressable object store for the evaluator/fetch path, with configurable width and depth.
- Valid/ready request and response channels, registered 1-cycle read latency, and per-access bounds status.
- Hardware clear sequencer fills every word with NIL_WORD after reset, so memory contents are defined before first use.

Parameters:
- WORD_W, 32, object word width in bits (matches WORD_SIZE in general package).
- DEPTH, 128, number of words; any value >= 2, not required to be a power of two.
- ADDR_W, 8, request address width; must satisfy 2**ADDR_W >= DEPTH. Addresses >= DEPTH are out of bounds.
- NIL_WORD, 0, clear value written to every location during init.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_data  in  WORD_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready.
- rsp_data  out  WORD_W  read data; NIL_WORD for write responses.
- rsp_status  out  mem_status_t  mem_ok or mem_oob for the access.
- init_done  out  1  clear sequence finished.

Behaviour:
- Reset (async assert, sync release): state = CLEAR, clr_ptr = 0, init_done = 0, req_ready = 0, rsp_valid = 0, rsp_data = NIL_WORD, rsp_status = mem_ok.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle write NIL_WORD to mem[clr_ptr], then clr_ptr++. When clr_ptr == DEPTH-1 is written, go to RUN next cycle. Clear takes exactly DEPTH cycles after reset release; init_done = 1 from the first RUN cycle.
  - RUN: state is held until reset. Requests are ignored in CLEAR; req_ready is 0 there.
- Response buffer: single entry.
  - req_ready = (state == RUN) && (!rsp_valid || rsp_ready). Same-cycle drain-and-refill gives full throughput of 1 access/cycle.
- Accepted read, in bounds: rsp_data = mem[req_addr], rsp_status = mem_ok, rsp_valid = 1 on the next edge (latency 1).
- Accepted read, out of bounds (req_addr >= DEPTH): rsp_data = mem[0], rsp_status = mem_oob.
- Accepted write, in bounds: mem[req_addr] <= req_data. A response is still produced: rsp_data = NIL_WORD, rsp_status = mem_ok, latency 1.
- Accepted write, out of bounds: memory is unchanged; the response carries status mem_oob.
- Response hold: rsp_valid, rsp_data and rsp_status stay stable while rsp_valid && !rsp_ready. rsp_valid clears after the handshake unless a new request is accepted in the same cycle.
- Read-after-write, back to back to the same address: the read returns the new data. The write is committed on the earlier edge, so no bypass is needed.
- Request fields are sampled only on the accept edge; inputs are don't-care otherwise.
- Reset mid-operation: any pending response is dropped and the clear restarts from address 0.
- Bounds compare uses the full ADDR_W width. There is no wrap-around and no truncation of the address.
- No X on outputs after reset. The memory array has no reset; it is defined by the clear sequence.

Decomposition:
- general package:
  - mem_status_t enum {mem_ok, mem_oob}, already present; extend the enum there if needed, not locally.
  - WORD_SIZE.
  - Localparam OBJ_MEM_DEPTH default.
- Single sub-module obj_mem_array: plain synchronous 1R1W storage (DEPTH x WORD_W, registered read) so it can infer block RAM.
- obj_mem holds the FSM, clear pointer, bounds check, mux between clear writes and user writes, and the response register.

Test Plan:
- Reset, DEPTH=128: init_done = 0 and req_ready = 0 for exactly 128 cycles after rst_n rises, then both = 1. A read of every address 0..127 returns 0 with mem_ok.
- Write 0xDEADBEEF to addr 5, then read addr 5 the next cycle -> write rsp has status mem_ok; read rsp_data = 0xDEADBEEF one cycle after accept; sustained 1 response/cycle.
- Write 0x11 to addr 0, then read addr 200 -> rsp_status = mem_oob, rsp_data = 0x11. Write 0x22 to addr 128 -> mem_oob, and a follow-up read of addr 0 is still 0x11.
- Hold rsp_ready = 0 for 4 cycles with req_valid high -> req_ready = 0, rsp fields stable. Raising rsp_ready -> same-cycle handshake and new accept, with no lost or duplicated response.
- Assert rst_n = 0 mid-clear (cycle 60) and mid-response -> rsp_valid drops immediately. Clear restarts and completes 128 cycles after release; the earlier write to addr 5 now reads 0.
- Non-power-of-two DEPTH=100, ADDR_W=7: addr 99 -> mem_ok; addr 100 and addr 127 -> mem_oob; clear lasts 100 cycles.
